// File: rtl/vape_exec_atomicity.sv
// vape_exec_atomicity: upstream atomicity monitor for the executable region (ER).
// Tracks entry at ER_min, exit via ER_max, and flags any interrupt/DMA or illegal
// control flow while inside ER. exec_abort feeds the EXEC-flag/reset path and
// er_done pulses once per clean ER completion.
// Optional feature macro: VAPE_ER_TIMEOUT_EN bounds the number of cycles in RUN
// to TIMEOUT_CYCLES. Without it, RUN duration is unbounded.
module vape_exec_atomicity #(
    parameter logic [15:0] RESET_HANDLER  = 16'h0000,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic        irq,
    input  logic        dma_en,
    input  logic [15:0] ER_min,
    input  logic [15:0] ER_max,
    output logic        exec_abort,
    output logic        er_active,
    output logic        er_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DONE  = 2'b10,
        ABORT = 2'b11
    } state_t;

    state_t state;
    state_t next;

    logic in_er;
    logic at_min;
    logic at_max;
    logic intr;
    logic timeout_hit;

    // An inverted region (ER_min > ER_max) makes in_er permanently false,
    // and the boundary matches are qualified by in_er so they cannot fire either.
    assign in_er  = (pc >= ER_min) && (pc <= ER_max);
    assign at_min = in_er && (pc == ER_min);
    assign at_max = in_er && (pc == ER_max);
    assign intr   = irq || dma_en;

`ifdef VAPE_ER_TIMEOUT_EN
    logic [15:0] run_cnt;

    assign timeout_hit = (state == RUN) && (run_cnt == (TIMEOUT_CYCLES - 16'd1));

    // Run-length counter: restarts on every entry to RUN, counts while staying in RUN.
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            run_cnt <= 16'd0;
        end else if (next == RUN) begin
            if (state == RUN)
                run_cnt <= run_cnt + 16'd1;
            else
                run_cnt <= 16'd0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state decision; reset is handled in the register block so it wins over all events.
    always_comb begin
        next = state;
        unique case (state)
            IDLE: begin
                if (in_er) begin
                    if (intr)
                        next = ABORT;
                    else if (at_min)
                        next = at_max ? DONE : RUN;   // degenerate one-address ER completes at once
                    else
                        next = ABORT;                 // entered mid-region
                end
            end
            RUN: begin
                if (intr)
                    next = ABORT;
                else if (timeout_hit)
                    next = ABORT;
                else if (at_max)
                    next = DONE;
                else if (!in_er)
                    next = ABORT;                     // left ER without passing ER_max
                else
                    next = RUN;
            end
            DONE: begin
                if (at_max)
                    next = DONE;                      // exit instruction spanning several cycles
                else if (at_min)
                    next = intr ? ABORT : RUN;
                else if (in_er)
                    next = ABORT;
                else
                    next = IDLE;                      // irq/dma are legal once outside ER
            end
            ABORT: begin
                if (pc == RESET_HANDLER)
                    next = IDLE;
            end
            default: next = ABORT;
        endcase
    end

    // State and outputs registered from next-state, so outputs lag pc by one cycle.
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            state      <= ABORT;
            exec_abort <= 1'b1;
            er_active  <= 1'b0;
            er_done    <= 1'b0;
        end else begin
            state      <= next;
            exec_abort <= (next == ABORT);
            er_active  <= (next == RUN);
            er_done    <= (next == DONE) && ((state == RUN) || (state == IDLE));
        end
    end

endmodule

// File: tb/tb_vape_exec_atomicity.sv
// Testbench for vape_exec_atomicity: scoreboard of expected outputs pushed per
// stimulus cycle and popped one clock later when the DUT outputs are valid.
module tb_vape_exec_atomicity;

    localparam logic [15:0] TO = 16'd16;

    logic        clk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc;
    logic        irq;
    logic        dma_en;
    logic [15:0] ER_min;
    logic [15:0] ER_max;
    logic        exec_abort;
    logic        er_active;
    logic        er_done;

    int total = 0;
    int bad   = 0;
    int done_seen;
    int abort_seen;

    int m_st;   // 0 idle, 1 run, 2 done, 3 abort
    int m_cnt;

    logic [2:0] sb[$];

    always #5 clk = ~clk;

    vape_exec_atomicity #(
        .RESET_HANDLER (16'h0000),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .puc_rst   (puc_rst),
        .pc        (pc),
        .irq       (irq),
        .dma_en    (dma_en),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .exec_abort(exec_abort),
        .er_active (er_active),
        .er_done   (er_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of the monitor, one call per clock of stimulus.
    task automatic model_step(input logic r, input logic [15:0] p, input logic i,
                              input logic d, output logic [2:0] e);
        int  nx;
        bit  inr;
        bit  intr;
        bit  to;
        inr  = (p >= ER_min) && (p <= ER_max);
        intr = i || d;
        to   = 1'b0;
`ifdef VAPE_ER_TIMEOUT_EN
        to   = (m_st == 1) && (m_cnt == int'(TO) - 1);
`endif
        nx = m_st;
        if (r) nx = 3;
        else if (m_st == 0) begin
            if (inr) begin
                if (intr) nx = 3;
                else if (p == ER_min && p == ER_max) nx = 2;
                else if (p == ER_min) nx = 1;
                else nx = 3;
            end
        end else if (m_st == 1) begin
            if (intr || to) nx = 3;
            else if (inr && p == ER_max) nx = 2;
            else if (!inr) nx = 3;
        end else if (m_st == 2) begin
            if (inr && p == ER_max) nx = 2;
            else if (inr && p == ER_min) nx = intr ? 3 : 1;
            else if (inr) nx = 3;
            else nx = 0;
        end else begin
            if (p == 16'h0000) nx = 0;
        end
        e = {nx == 3, nx == 1, (nx == 2) && (m_st != 2) && !r};
        if (r) m_cnt = 0;
        else if (nx == 1) m_cnt = (m_st == 1) ? m_cnt + 1 : 0;
        m_st = nx;
    endtask

    task automatic step(input logic r, input logic [15:0] p, input logic i, input logic d);
        logic [2:0] e;
        logic [2:0] got;
        puc_rst = r;
        pc      = p;
        irq     = i;
        dma_en  = d;
        model_step(r, p, i, d, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = {exec_abort, er_active, er_done};
        e   = sb.pop_front();
        chk("exec_abort", {31'd0, got[2]}, {31'd0, e[2]});
        chk("er_active",  {31'd0, got[1]}, {31'd0, e[1]});
        chk("er_done",    {31'd0, got[0]}, {31'd0, e[0]});
        if (got[0]) done_seen++;
        if (got[2]) abort_seen++;
    endtask

    task automatic go(input logic [15:0] p);
        step(1'b0, p, 1'b0, 1'b0);
    endtask

    initial begin
        logic [15:0] rp;
        int          sel;
        m_st    = 3;
        m_cnt   = 0;
        puc_rst = 1'b1;
        pc      = 16'h0000;
        irq     = 1'b0;
        dma_en  = 1'b0;
        ER_min  = 16'hE000;
        ER_max  = 16'hE0FE;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 16'h0000, 1'b0, 1'b0);
        chk("rst_abort",  {31'd0, exec_abort}, 32'd1);
        chk("rst_active", {31'd0, er_active},  32'd0);
        go(16'h0000);
        chk("idle_abort", {31'd0, exec_abort}, 32'd0);

        // Clean walk through the whole ER
        done_seen  = 0;
        abort_seen = 0;
        for (int a = 16'hE000; a <= 16'hE0FE; a++) go(16'(a));
        go(16'h4000);
`ifdef VAPE_ER_TIMEOUT_EN
        chk("walk_done_cnt", done_seen, 0);
`else
        chk("walk_done_cnt", done_seen, 1);
        chk("walk_abort_cnt", abort_seen, 0);
`endif
        go(16'h0000);

        // Mid-region entry, sticky until reset handler
        go(16'h4000);
        go(16'hE010);
        chk("mid_entry", {31'd0, exec_abort}, 32'd1);
        go(16'h5000);
        go(16'hE000);
        chk("abort_sticky", {31'd0, exec_abort}, 32'd1);
        go(16'h0000);
        chk("abort_clear", {31'd0, exec_abort}, 32'd0);

        // irq then dma inside RUN
        for (int k = 0; k < 2; k++) begin
            done_seen = 0;
            go(16'hE000);
            go(16'hE010);
            step(1'b0, 16'hE020, k == 0, k == 1);
            chk("intr_active", {31'd0, er_active}, 32'd0);
            go(16'hE021);
            go(16'hE0FE);
            chk("intr_no_done", done_seen, 0);
            go(16'h0000);
        end

        // Illegal exit from RUN
        go(16'hE000);
        go(16'hE020);
        go(16'h4000);
        chk("illegal_exit", {31'd0, exec_abort}, 32'd1);
        go(16'h0000);

        // Multi-cycle exit then re-entry
        done_seen = 0;
        go(16'hE000);
        go(16'hE001);
        go(16'hE0FE);
        go(16'hE0FE);
        go(16'hE0FE);
        go(16'hE000);
        chk("reentry_done_cnt", done_seen, 1);
        chk("reentry_active", {31'd0, er_active}, 32'd1);
        go(16'hE001);
        step(1'b1, 16'hE002, 1'b1, 1'b0);
        chk("rst_mid_abort", {31'd0, exec_abort}, 32'd1);
        go(16'h0000);

        // Re-entry from DONE with irq aborts; irq in DONE outside ER is legal
        go(16'hE000);
        go(16'hE0FE);
        step(1'b0, 16'hE000, 1'b1, 1'b0);
        go(16'h0000);
        go(16'hE000);
        go(16'hE0FE);
        step(1'b0, 16'h4000, 1'b1, 1'b1);
        chk("done_irq_legal", {31'd0, exec_abort}, 32'd0);

        // Degenerate single-address ER
        ER_min = 16'h3000;
        ER_max = 16'h3000;
        go(16'h1000);
        go(16'h3000);
        chk("degen_done", {31'd0, er_done}, 32'd1);
        go(16'h3000);
        go(16'h1000);

        // Inverted ER never activates
        ER_min = 16'h5000;
        ER_max = 16'h4000;
        go(16'h5000);
        go(16'h4800);
        go(16'h4000);
        chk("inverted_idle", {31'd0, exec_abort | er_active}, 32'd0);

        // Long loop inside ER: timeout behaviour
        ER_min     = 16'hE000;
        ER_max     = 16'hE0FE;
        abort_seen = 0;
        go(16'hE000);
        for (int n = 0; n < 300; n++) go(16'hE001 + 16'(n % 5));
`ifdef VAPE_ER_TIMEOUT_EN
        chk("timeout_abort", {31'd0, exec_abort}, 32'd1);
`else
        chk("no_timeout", abort_seen, 0);
`endif
        go(16'h4000);
        go(16'h0000);

        // Random traffic biased towards region boundaries
        for (int n = 0; n < 500; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    rp = 16'hE000;
                2:       rp = 16'hE0FE;
                3, 4:    rp = 16'hE000 + 16'($urandom_range(1, 16));
                5:       rp = 16'h0000;
                6:       rp = 16'hE0FF;
                default: rp = 16'(n[3:0]) + ((n % 3 == 0) ? 16'h4000 : 16'hE010);
            endcase
            step($urandom_range(0, 60) == 0, rp,
                 $urandom_range(0, 12) == 0, $urandom_range(0, 12) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
